lsu_byte_sequencer: RTL and testbench



---
 rtl/lsu_byte_sequencer_if.sv | 36 +++
 rtl/lsu_byte_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_byte_sequencer_if.sv
// Bundle of the request/response handshake and the byte-wide memory port
// used by lsu_byte_sequencer.
//   req_*  : core-side load/store request (valid/ready)
//   resp_* : one-cycle completion pulse with extended load data and error flag
//   mem_*  : byte-wide, registered-read data memory port
// Modports: master = core + memory environment, slave = the sequencer.
interface lsu_byte_sequencer_if #(
   parameter int ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_ctrl;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport master (
      output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Load/store initiator: splits one B/H/W request into little-endian byte
// accesses on a byte-wide registered-read memory, assembles and extends load
// data, and returns a single-cycle response.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : lsu_byte_sequencer_if.slave (req_*, resp_*, mem_* signals)
// ctrl encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal,
// and unsigned sizes are illegal for stores.
module lsu_byte_sequencer #(
   parameter int MEM_BYTES = 64,
   parameter int ADDR_W    = 32
) (
   input logic                 clk,
   input logic                 rst,
   lsu_byte_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       wsh_q, wsh_d;     // store bytes not yet issued, next in [7:0]
   logic [31:0]       res_q, res_d;     // load bytes assembled so far
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;

   logic [1:0]        req_last_idx;
   logic [1:0]        cur_last_idx;
   logic [ADDR_W:0]   req_last_addr;
   logic              req_illegal;
   logic              req_oor;
   logic [1:0]        cap_idx;
   logic [31:0]       cap;

   function automatic logic [1:0] last_idx(input logic [1:0] sz);
      case (sz)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] c, input logic [31:0] d);
      case (c[1:0])
         2'b00:   extend = c[2] ? {24'h000000, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   extend = c[2] ? {16'h0000, d[15:0]}  : {{16{d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   always_comb begin
      req_last_idx  = last_idx(bus.req_ctrl[1:0]);
      cur_last_idx  = last_idx(ctrl_q[1:0]);
      req_illegal   = (bus.req_ctrl[1:0] == 2'b11) ||
                      (bus.req_ctrl[2] && (bus.req_we || bus.req_ctrl[1]));
      // one extra bit so addr+N-1 cannot wrap below MEM_BYTES
      req_last_addr = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_last_idx);
      req_oor       = req_last_addr >= (ADDR_W+1)'(MEM_BYTES);

      // read data lags its strobe by one cycle; in DRAIN idx already points
      // at the final byte because it is not advanced on the last strobe
      cap_idx = (state_q == DRAIN) ? idx_q : idx_q - 2'd1;
      cap     = res_q;
      cap[{cap_idx, 3'b000} +: 8] = bus.mem_rdata;
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      ctrl_d       = ctrl_q;
      idx_d        = idx_q;
      wsh_d        = wsh_q;
      res_d        = res_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d   = bus.req_we;
               ctrl_d = bus.req_ctrl;
               idx_d  = 2'd0;
               res_d  = '0;
               if (req_illegal || req_oor) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  mem_en_d    = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = bus.req_addr;
                  mem_wdata_d = bus.req_wdata[7:0];
                  wsh_d       = bus.req_wdata[31:8];
               end
            end
         end
         ISSUE: begin
            if (!we_q && idx_q != 2'd0) res_d = cap;
            if (idx_q == cur_last_idx) begin
               if (we_q) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               idx_d       = idx_q + 2'd1;
               mem_en_d    = 1'b1;
               mem_we_d    = we_q;
               mem_addr_d  = mem_addr_q + ADDR_W'(1);
               mem_wdata_d = wsh_q[7:0];
               wsh_d       = {8'h00, wsh_q[23:8]};
            end
         end
         DRAIN: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = extend(ctrl_q, cap);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         ctrl_q       <= '0;
         idx_q        <= '0;
         wsh_q        <= '0;
         res_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         ctrl_q       <= ctrl_d;
         idx_q        <= idx_d;
         wsh_q        <= wsh_d;
         res_q        <= res_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;

   logic clk;
   logic rst;
   logic mem_clr;

   lsu_byte_sequencer_if #(.ADDR_W(32)) bus ();

   lsu_byte_sequencer #(.MEM_BYTES(64), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // byte memory with registered read
   logic [7:0] mem [0:63];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
         bus.mem_rdata <= 8'h00;
      end else if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem[bus.mem_addr[5:0]];
      end
   end

   // strobe / response log, stamped by falling-edge count
   int          ncnt = 0;
   int          nresp = 0;
   logic [31:0] st_a[$];
   logic [31:0] st_d[$];
   logic [31:0] st_w[$];
   int          st_c[$];
   always @(negedge clk) begin
      ncnt <= ncnt + 1;
      if (bus.mem_en) begin
         st_a.push_back(bus.mem_addr);
         st_d.push_back({24'h0, bus.mem_wdata});
         st_w.push_back({31'h0, bus.mem_we});
         st_c.push_back(ncnt + 1);
      end
      if (bus.resp_valid) nresp <= nresp + 1;
   end

   int          npass = 0;
   int          nfail = 0;
   int          ntot  = 0;
   int          base, s0, s1, lat, nr0;
   logic [31:0] rd;
   logic        er;
   logic        rdy [1:3];
   logic        rv  [1:3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // check strobe i of the current transaction; data only checked for stores
   task automatic chk_strobe(input string tag, input int i, input logic [31:0] a,
                             input logic we, input logic [7:0] d, input int rel);
      if (s0 + i < st_a.size()) begin
         chk($sformatf("%s_addr%0d", tag, i), st_a[s0+i], a);
         chk($sformatf("%s_we%0d", tag, i), st_w[s0+i], {31'h0, we});
         chk($sformatf("%s_cyc%0d", tag, i), st_c[s0+i] - base, rel);
         if (we) chk($sformatf("%s_data%0d", tag, i), st_d[s0+i], {24'h0, d});
      end else begin
         ntot++;
         nfail++;
         $error("FAIL %s_strobe%0d: observed none expected addr %h", tag, i, a);
      end
   endtask

   task automatic wait_resp();
      lat = -1;
      rd  = 'x;
      er  = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            lat = k;
            rd  = bus.resp_rdata;
            er  = bus.resp_err;
            break;
         end
      end
      #1;
   endtask

   task automatic xact(input logic we, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] wd);
      int guard;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_ctrl  = c;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      base = ncnt;
      s0   = st_a.size();
      wait_resp();
   endtask

   initial begin
      rst           = 1'b1;
      mem_clr       = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_ctrl  = 3'b000;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_err",   {31'h0, bus.resp_err}, 32'h0);
      chk("rst_mem_en",     {31'h0, bus.mem_en}, 32'h0);
      chk("rst_mem_we",     {31'h0, bus.mem_we}, 32'h0);
      chk("rst_mem_addr",   bus.mem_addr, 32'h0);
      chk("rst_mem_wdata",  {24'h0, bus.mem_wdata}, 32'h0);
      rst     = 1'b0;
      mem_clr = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

      // SW 0x10
      xact(1'b1, 3'b010, 32'h10, 32'h8BADF00D);
      chk("sw_lat", lat, 5);
      chk("sw_err", {31'h0, er}, 32'h0);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_nstrobe", st_a.size() - s0, 4);
      chk_strobe("sw", 0, 32'h10, 1'b1, 8'h0D, 1);
      chk_strobe("sw", 1, 32'h11, 1'b1, 8'hF0, 2);
      chk_strobe("sw", 2, 32'h12, 1'b1, 8'hAD, 3);
      chk_strobe("sw", 3, 32'h13, 1'b1, 8'h8B, 4);

      // loads with extension
      xact(1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb_rdata", rd, 32'hFFFFFF8B);
      chk("lb_lat", lat, 3);
      chk_strobe("lb", 0, 32'h13, 1'b0, 8'h00, 1);
      xact(1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu_rdata", rd, 32'h0000008B);
      xact(1'b0, 3'b001, 32'h12, 32'h0);
      chk("lh_rdata", rd, 32'hFFFF8BAD);
      chk("lh_lat", lat, 4);
      xact(1'b0, 3'b101, 32'h12, 32'h0);
      chk("lhu_rdata", rd, 32'h00008BAD);
      xact(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_rdata", rd, 32'h8BADF00D);
      chk("lw_lat", lat, 6);
      chk("lw_err", {31'h0, er}, 32'h0);
      chk("lw_nstrobe", st_a.size() - s0, 4);

      // misaligned word
      xact(1'b1, 3'b000, 32'h14, 32'hFFFFFF3C);
      chk("sb_lat", lat, 2);
      chk_strobe("sb", 0, 32'h14, 1'b1, 8'h3C, 1);
      xact(1'b0, 3'b010, 32'h11, 32'h0);
      chk("lwmis_rdata", rd, 32'h3C8BADF0);
      chk("lwmis_lat", lat, 6);
      chk("lwmis_err", {31'h0, er}, 32'h0);
      chk_strobe("lwmis", 0, 32'h11, 1'b0, 8'h00, 1);
      chk_strobe("lwmis", 1, 32'h12, 1'b0, 8'h00, 2);
      chk_strobe("lwmis", 2, 32'h13, 1'b0, 8'h00, 3);
      chk_strobe("lwmis", 3, 32'h14, 1'b0, 8'h00, 4);

      // errors and range boundary
      xact(1'b0, 3'b011, 32'h0, 32'h0);
      chk("ill011_lat", lat, 1);
      chk("ill011_err", {31'h0, er}, 32'h1);
      chk("ill011_rdata", rd, 32'h0);
      chk("ill011_nstrobe", st_a.size() - s0, 0);
      xact(1'b1, 3'b100, 32'h0, 32'h12345678);
      chk("sbu_lat", lat, 1);
      chk("sbu_err", {31'h0, er}, 32'h1);
      chk("sbu_nstrobe", st_a.size() - s0, 0);
      chk("sbu_mem0", {24'h0, mem[0]}, 32'h0);
      xact(1'b0, 3'b010, 32'h3E, 32'h0);
      chk("lw3e_err", {31'h0, er}, 32'h1);
      chk("lw3e_lat", lat, 1);
      chk("lw3e_nstrobe", st_a.size() - s0, 0);
      xact(1'b0, 3'b001, 32'h3F, 32'h0);
      chk("lh3f_err", {31'h0, er}, 32'h1);
      xact(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0);
      chk("lbwrap_err", {31'h0, er}, 32'h1);
      xact(1'b1, 3'b000, 32'h3F, 32'h00000080);
      chk("sb3f_err", {31'h0, er}, 32'h0);
      chk("sb3f_lat", lat, 2);
      xact(1'b0, 3'b000, 32'h3F, 32'h0);
      chk("lb3f_err", {31'h0, er}, 32'h0);
      chk("lb3f_lat", lat, 3);
      chk("lb3f_rdata", rd, 32'hFFFFFF80);

      // reset in the middle of a word store
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_ctrl  = 3'b010;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h11223344;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      base = ncnt;
      s0   = st_a.size();
      nr0  = nresp;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_mem_en", {31'h0, bus.mem_en}, 32'h0);
      @(negedge clk);
      chk("rstmid_req_ready", {31'h0, bus.req_ready}, 32'h1);
      repeat (4) @(negedge clk);
      #1;
      chk("rstmid_nstrobe", st_a.size() - s0, 2);
      chk("rstmid_nresp", nresp - nr0, 0);
      chk("rstmid_m20", {24'h0, mem[32]}, 32'h44);
      chk("rstmid_m21", {24'h0, mem[33]}, 32'h33);
      chk("rstmid_m22", {24'h0, mem[34]}, 32'h00);
      chk("rstmid_m23", {24'h0, mem[35]}, 32'h00);

      // back-to-back: valid held high, second request presented while busy
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_ctrl  = 3'b000;
      bus.req_addr  = 32'h30;
      bus.req_wdata = 32'h000000A5;
      @(posedge clk);
      #1;
      bus.req_we    = 1'b0;
      bus.req_ctrl  = 3'b100;
      bus.req_addr  = 32'h30;
      bus.req_wdata = 32'h0;
      base = ncnt;
      s0   = st_a.size();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         rdy[k] = bus.req_ready;
         rv[k]  = bus.resp_valid;
      end
      chk("b2b_ready1", {31'h0, rdy[1]}, 32'h0);
      chk("b2b_ready2", {31'h0, rdy[2]}, 32'h0);
      chk("b2b_ready3", {31'h0, rdy[3]}, 32'h1);
      chk("b2b_resp2",  {31'h0, rv[2]}, 32'h1);
      chk("b2b_resp3",  {31'h0, rv[3]}, 32'h0);
      chk("b2b_nstrobe1", st_a.size() - s0, 1);
      chk_strobe("b2b1", 0, 32'h30, 1'b1, 8'hA5, 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      base = ncnt;
      s1   = st_a.size();
      wait_resp();
      chk("b2b2_lat", lat, 3);
      chk("b2b2_rdata", rd, 32'h000000A5);
      chk("b2b2_err", {31'h0, er}, 32'h0);
      chk("b2b2_nstrobe", st_a.size() - s1, 1);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
